zion_basic_circuit_lib_rr_reg_arbiter: RTL and testbench



---
 rtl/zion_basic_circuit_lib_rr_reg_arbiter_pkg.sv | 35 +++
 rtl/zion_basic_circuit_lib_rr_reg_arbiter_if.sv | 34 +++
 rtl/zion_basic_circuit_lib_rr_pick.sv | 24 ++
 rtl/zion_basic_circuit_lib_rr_reg_arbiter.sv | 133 +++++++++++++
 tb/tb_zion_basic_circuit_lib_rr_reg_arbiter.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/zion_basic_circuit_lib_rr_reg_arbiter_pkg.sv
// Shared types and the rotate-priority search for the round-robin register arbiter.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
package zion_basic_circuit_lib_arb_pkg;

    // ARB: free arbitration; LOCK: one requester owns the output until its last beat.
    typedef enum logic {ARB, LOCK} arb_state_e;

    localparam int MAX_REQ = 16;

    // Returns {found, idx}. The search starts at ptr and wraps at n using an
    // explicit compare, so non-power-of-two requester counts wrap correctly.
    // Requires ptr < n <= 16.
    function automatic logic [4:0] rr_pick(input logic [15:0] req,
                                           input logic [3:0]  ptr,
                                           input logic [4:0]  n);
        logic       found;
        logic [3:0] idx;
        logic [4:0] k;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            k = {1'b0, ptr} + 5'(i);
            if (k >= n) begin
                k = k - n;
            end
            if ((5'(i) < n) && !found && req[k[3:0]]) begin
                found = 1'b1;
                idx   = k[3:0];
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/zion_basic_circuit_lib_rr_reg_arbiter_if.sv
// Handshake bundle between NUM_REQ producers, the arbiter and one consumer.
// Latency: n/a (wires only).
// Backpressure: iRdy from the consumer; oGnt back to the producers.
// Ports: iClr sync clear; iReq/iLast/iDat per-requester beat; oGnt one-hot accept;
//        oVld/oDat/oIdx/oLast registered output beat; iRdy downstream ready.
interface zion_basic_circuit_lib_rr_reg_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic                     iClr;
    logic [NUM_REQ-1:0]       iReq;
    logic [NUM_REQ-1:0]       iLast;
    logic [NUM_REQ*WIDTH-1:0] iDat;
    logic [NUM_REQ-1:0]       oGnt;
    logic                     oVld;
    logic [WIDTH-1:0]         oDat;
    logic [IDX_W-1:0]         oIdx;
    logic                     oLast;
    logic                     iRdy;

    // master: the arbiter side
    modport master (
        input  iClr, iReq, iLast, iDat, iRdy,
        output oGnt, oVld, oDat, oIdx, oLast
    );

    // slave: the producers and consumer around the arbiter
    modport slave (
        output iClr, iReq, iLast, iDat, iRdy,
        input  oGnt, oVld, oDat, oIdx, oLast
    );
endinterface

// File: rtl/zion_basic_circuit_lib_rr_pick.sv
// Rotate-priority encoder: first requester at or above iPtr, wrapping at NUM_REQ.
// Latency: combinational.
// Backpressure: none.
// Ports: iReq request vector, iPtr search start; oFound any request, oIdx winner.
module zion_basic_circuit_lib_rr_pick
    import zion_basic_circuit_lib_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] iReq,
    input  logic [IDX_W-1:0]   iPtr,
    output logic               oFound,
    output logic [IDX_W-1:0]   oIdx
);
    logic [4:0] res;
    logic       unused_res;

    assign res        = rr_pick(16'(iReq), 4'(iPtr), 5'(NUM_REQ));
    assign oFound     = res[4];
    assign oIdx       = res[IDX_W-1:0];
    // Index bits above IDX_W are always zero for legal NUM_REQ.
    assign unused_res = ^res;
endmodule

// File: rtl/zion_basic_circuit_lib_rr_reg_arbiter.sv
// Round-robin arbiter with packet lock feeding one clearable output holding register.
// Latency: 1 cycle from accepted beat (oGnt) to oVld/oDat; oGnt is combinational.
// Backpressure: register reloads when empty or iRdy=1 (no bubble); otherwise oGnt=0 and outputs hold.
// Ports: clk, rst (async, active high), bus (master modport of the handshake interface).
module zion_basic_circuit_lib_rr_reg_arbiter
    import zion_basic_circuit_lib_arb_pkg::*;
#(
    parameter int               NUM_REQ  = 4,
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] INI_DATA = '0,
    parameter int               IDX_W    = $clog2(NUM_REQ)
) (
    input  logic clk,
    input  logic rst,
    zion_basic_circuit_lib_rr_reg_arbiter_if.master bus
);
    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("NUM_REQ must be in 2..16");
    end

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   own_q, own_d;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic               ld;
    logic               gnt_vld;
    logic [IDX_W-1:0]   g;
    logic [NUM_REQ-1:0] gnt;

    logic               vld_q;
    logic [WIDTH-1:0]   dat_q;
    logic [IDX_W-1:0]   idx_q;
    logic               last_q;

    zion_basic_circuit_lib_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .iReq   (bus.iReq),
        .iPtr   (ptr_q),
        .oFound (pick_found),
        .oIdx   (pick_idx)
    );

    assign ld = !vld_q || bus.iRdy;

    always_comb begin
        gnt_vld = 1'b0;
        g       = pick_idx;
        gnt     = '0;
        state_d = state_q;
        own_d   = own_q;
        ptr_d   = ptr_q;
        // Clear suppresses the grant so no producer beat is consumed that cycle.
        if (ld && !bus.iClr) begin
            if (state_q == ARB) begin
                gnt_vld = pick_found;
                g       = pick_idx;
            end else begin
                // Only the owner may advance, even when it is idle.
                gnt_vld = bus.iReq[own_q];
                g       = own_q;
            end
        end
        if (gnt_vld) begin
            gnt[g] = 1'b1;
            if (bus.iLast[g]) begin
                state_d = ARB;
                ptr_d   = (int'(g) == NUM_REQ - 1) ? '0 : g + 1'b1;
            end else begin
                state_d = LOCK;
                own_d   = g;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB;
            ptr_q   <= '0;
            own_q   <= '0;
        end else if (bus.iClr) begin
            state_q <= ARB;
            ptr_q   <= '0;
            own_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
        end
    end

    // Output holding register; clear discards any beat held for the consumer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= 1'b0;
            dat_q  <= INI_DATA;
            idx_q  <= '0;
            last_q <= 1'b0;
        end else if (bus.iClr) begin
            vld_q  <= 1'b0;
            dat_q  <= INI_DATA;
            idx_q  <= '0;
            last_q <= 1'b0;
        end else if (ld) begin
            if (gnt_vld) begin
                vld_q  <= 1'b1;
                dat_q  <= bus.iDat[int'(g)*WIDTH +: WIDTH];
                idx_q  <= g;
                last_q <= bus.iLast[g];
            end else begin
                vld_q  <= 1'b0;
            end
        end
    end

    assign bus.oGnt  = gnt;
    assign bus.oVld  = vld_q;
    assign bus.oDat  = dat_q;
    assign bus.oIdx  = idx_q;
    assign bus.oLast = last_q;

    always_comb begin
        assert ($onehot0(gnt));
        assert ((gnt & ~bus.iReq) == '0);
        assert ((state_q != LOCK) || (gnt == '0) || (gnt == (NUM_REQ'(1) << own_q)));
    end

    assert property (@(posedge clk) disable iff (rst)
        (vld_q && !bus.iRdy && !bus.iClr) |=> ($stable(dat_q) && $stable(idx_q) && $stable(last_q)));

endmodule

// File: tb/tb_zion_basic_circuit_lib_rr_reg_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
// Latency: model expects oGnt same cycle, registered beat one cycle later.
// Backpressure: random iRdy and occasional iClr exercise hold and discard paths.
module tb_zion_basic_circuit_lib_rr_reg_arbiter;
    localparam int           N   = 4;
    localparam int           W   = 8;
    localparam logic [W-1:0] INI = 8'h5A;

    logic clk;
    logic rst;

    zion_basic_circuit_lib_rr_reg_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

    zion_basic_circuit_lib_rr_reg_arbiter #(
        .NUM_REQ  (N),
        .WIDTH    (W),
        .INI_DATA (INI)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Behavioural model: output beat, round-robin start point, and the
    // requester currently mid-packet (-1 when nobody holds the output).
    bit         m_vld;
    logic [7:0] m_dat;
    int         m_idx;
    bit         m_last;
    int         m_ptr;
    int         m_own;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_vld  = 1'b0;
        m_dat  = INI;
        m_idx  = 0;
        m_last = 1'b0;
        m_ptr  = 0;
        m_own  = -1;
    endtask

    function automatic int model_grant();
        if (bus.iClr || !(!m_vld || bus.iRdy)) return -1;
        if (m_own >= 0) return bus.iReq[m_own] ? m_own : -1;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (bus.iReq[k]) return k;
        end
        return -1;
    endfunction

    task automatic check_outputs(input string tag);
        check_eq({tag, ".vld"},  32'(bus.oVld),  32'(m_vld));
        check_eq({tag, ".dat"},  32'(bus.oDat),  32'(m_dat));
        check_eq({tag, ".idx"},  32'(bus.oIdx),  32'(m_idx));
        check_eq({tag, ".last"}, 32'(bus.oLast), 32'(m_last));
    endtask

    // Called at posedge+1: drive, check mid-cycle, advance model across the edge.
    task automatic cycle(input logic [3:0] req, input logic [3:0] last, input logic [31:0] dat,
                         input logic rdy, input logic clr, input string tag);
        int g;
        bit ld;
        bus.iReq  = req;
        bus.iLast = last;
        bus.iDat  = dat;
        bus.iRdy  = rdy;
        bus.iClr  = clr;
        #2;
        g  = model_grant();
        ld = !m_vld || rdy;
        check_eq({tag, ".gnt"}, 32'(bus.oGnt), (g >= 0) ? (32'd1 << g) : 32'd0);
        check_outputs(tag);
        @(posedge clk);
        #1;
        if (clr) begin
            model_reset();
        end else if (ld) begin
            if (g >= 0) begin
                m_vld  = 1'b1;
                m_dat  = dat[g*8 +: 8];
                m_idx  = g;
                m_last = last[g];
                if (last[g]) begin
                    m_ptr = (g + 1) % N;
                    m_own = -1;
                end else begin
                    m_own = g;
                end
            end else begin
                m_vld = 1'b0;
            end
        end
    endtask

    int lock_idx[5] = '{1, 1, 1, 2, 0};

    initial begin
        rst       = 1'b1;
        bus.iReq  = '0;
        bus.iLast = '0;
        bus.iDat  = '0;
        bus.iRdy  = 1'b0;
        bus.iClr  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        check_eq("reset.gnt", 32'(bus.oGnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Idle: nothing requested, register stays empty at its initial value.
        for (int i = 0; i < 10; i++) cycle(4'h0, 4'h0, $urandom, 1'b1, 1'b0, "idle");

        // Fairness with single-beat packets on every requester.
        for (int i = 0; i < 5; i++) begin
            cycle(4'hF, 4'hF, $urandom, 1'b1, 1'b0, "rr");
            check_eq("rr_seq", 32'(bus.oIdx), 32'(i % N));
        end

        // Three-beat packet from requester 1 while 0 and 2 keep requesting.
        for (int b = 0; b < 5; b++) begin
            cycle(4'b0111, 4'b0101 | ((b == 2) ? 4'b0010 : 4'b0000), $urandom, 1'b1, 1'b0, "lock");
            check_eq("lock_seq", 32'(bus.oIdx), 32'(lock_idx[b]));
        end

        // Backpressure: load a beat, stall five cycles, then release.
        cycle(4'b0011, 4'hF, $urandom, 1'b1, 1'b0, "bp_fill");
        for (int i = 0; i < 5; i++) cycle(4'b0011, 4'hF, $urandom, 1'b0, 1'b0, "bp_stall");
        cycle(4'b0011, 4'hF, $urandom, 1'b1, 1'b0, "bp_release");

        // Clear in the middle of a requester-3 packet.
        cycle(4'b1000, 4'h0, $urandom, 1'b1, 1'b0, "clr_b1");
        cycle(4'b1000, 4'h0, $urandom, 1'b1, 1'b0, "clr_b2");
        cycle(4'b1001, 4'h0, $urandom, 1'b1, 1'b1, "clr_pulse");
        cycle(4'b1001, 4'hF, $urandom, 1'b1, 1'b0, "clr_after");
        check_eq("clr_winner", 32'(bus.oIdx), 32'd0);

        // Async reset between edges while streaming.
        for (int i = 0; i < 3; i++) cycle(4'hF, 4'h5, $urandom, 1'b1, 1'b0, "pre_arst");
        bus.iRdy = 1'b1;
        bus.iReq = '0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("arst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("arst_rel");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(4'($urandom), 4'($urandom), $urandom,
                  ($urandom_range(3) != 0), ($urandom_range(31) == 0), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
